fsk_bit_mapper: RTL and testbench

- Upstream neighbour of the AXI-Stream sine/FSK stage in the 2FSK chain.
- Accepts packed 32-bit payload words over AXI-Stream slave and serializes them bit by bit.
- For each bit it emits REPEAT master beats carrying a frequency tuning word: cfg_ftw_mark for '1', cfg_ftw_space for '0'. The sine stage consumes these words.

---
 rtl/fsk_pkg.sv | 41 ++++
 rtl/fsk_bit_shifter.sv | 73 +++++++
 rtl/fsk_bit_mapper.sv | 125 ++++++++++++
 tb/tb_fsk_bit_mapper.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the 2FSK modulator chain: FSM encodings, legal
// tkeep patterns and default tuning words for a 50 MHz sample clock.
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } fsk_state_t;

    localparam logic [3:0] KEEP_1B = 4'h1;
    localparam logic [3:0] KEEP_2B = 4'h3;
    localparam logic [3:0] KEEP_3B = 4'h7;
    localparam logic [3:0] KEEP_4B = 4'hF;

    localparam logic [31:0] FTW_2MHZ_50M = 32'h0A3D70A4;
    localparam logic [31:0] FTW_1MHZ_50M = 32'h051EB852;

    function automatic logic keep_is_legal(input logic [3:0] keep);
        logic legal_s;
        case (keep)
            KEEP_1B, KEEP_2B, KEEP_3B, KEEP_4B: legal_s = 1'b1;
            default:                            legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

    // Index of the highest valid payload bit for a legal keep pattern.
    function automatic logic [4:0] keep_top_index(input logic [3:0] keep);
        logic [4:0] idx_s;
        case (keep)
            KEEP_1B: idx_s = 5'd7;
            KEEP_2B: idx_s = 5'd15;
            KEEP_3B: idx_s = 5'd23;
            KEEP_4B: idx_s = 5'd31;
            default: idx_s = 5'd0;
        endcase
        return idx_s;
    endfunction

endpackage

// File: rtl/fsk_bit_shifter.sv
// Holds the captured payload word and frozen tuning words, and walks the
// bit/repeat counters that select the tuning word for each master beat.
module fsk_bit_shifter
    import fsk_pkg::*;
#(
    parameter int REPEAT    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [3:0]  load_keep,
    input  logic        load_last,
    input  logic [31:0] load_mark,
    input  logic [31:0] load_space,
    input  logic        advance,
    output logic [31:0] ftw,
    output logic        final_beat,
    output logic        beat_last
);

    localparam logic [7:0] REP_MAX = 8'(REPEAT - 1);

    logic [31:0] word_r;
    logic [31:0] mark_r;
    logic [31:0] space_r;
    logic        last_r;
    logic [4:0]  bit_idx_r;
    logic [4:0]  end_idx_r;
    logic [7:0]  rep_r;
    logic        rep_wrap_s;

    assign rep_wrap_s = (rep_r == REP_MAX);

    // Capture a word on load; step repeat then bit counters on each accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_r    <= 32'h0;
            mark_r    <= 32'h0;
            space_r   <= 32'h0;
            last_r    <= 1'b0;
            bit_idx_r <= 5'd0;
            end_idx_r <= 5'd0;
            rep_r     <= 8'd0;
        end else if (load) begin
            word_r  <= load_data;
            mark_r  <= load_mark;
            space_r <= load_space;
            last_r  <= load_last;
            rep_r   <= 8'd0;
            if (MSB_FIRST) begin
                bit_idx_r <= keep_top_index(load_keep);
                end_idx_r <= 5'd0;
            end else begin
                bit_idx_r <= 5'd0;
                end_idx_r <= keep_top_index(load_keep);
            end
        end else if (advance) begin
            if (rep_wrap_s) begin
                rep_r     <= 8'd0;
                bit_idx_r <= MSB_FIRST ? (bit_idx_r - 5'd1) : (bit_idx_r + 5'd1);
            end else begin
                rep_r <= rep_r + 8'd1;
            end
        end
    end

    assign ftw        = word_r[bit_idx_r] ? mark_r : space_r;
    assign final_beat = (bit_idx_r == end_idx_r) && rep_wrap_s;
    assign beat_last  = final_beat && last_r;

endmodule

// File: rtl/fsk_bit_mapper.sv
// AXI-Stream payload-to-tuning-word mapper: serialises each payload word and
// emits REPEAT tuning-word beats per bit towards the sine stage.
module fsk_bit_mapper
    import fsk_pkg::*;
#(
    parameter int REPEAT    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] cfg_ftw_mark,
    input  logic [31:0] cfg_ftw_space,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        err_keep,
    output logic [1:0]  state_reg
);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        s_hs_s;
    logic        m_hs_s;
    logic        keep_ok_s;
    logic        load_s;
    logic        final_beat_s;
    logic        beat_last_s;
    logic        err_keep_r;
    logic [31:0] ftw_s;

    assign s_hs_s    = s_axis_tvalid & s_axis_tready;
    assign keep_ok_s = keep_is_legal(s_axis_tkeep);
    assign load_s    = s_hs_s & keep_ok_s;
    assign m_hs_s    = m_axis_tvalid & m_axis_tready;

    fsk_bit_shifter #(
        .REPEAT    (REPEAT),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_data  (s_axis_tdata),
        .load_keep  (s_axis_tkeep),
        .load_last  (s_axis_tlast),
        .load_mark  (cfg_ftw_mark),
        .load_space (cfg_ftw_space),
        .advance    (m_hs_s),
        .ftw        (ftw_s),
        .final_beat (final_beat_s),
        .beat_last  (beat_last_s)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (m_hs_s && final_beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // One-cycle error pulse for a consumed word with an illegal keep pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_keep_r <= 1'b0;
        end else begin
            err_keep_r <= s_hs_s & ~keep_ok_s;
        end
    end

    // Output decode from registered state and shifter contents.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep  = 4'h0;
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        case (state_r)
            ST_IDLE: s_axis_tready = ~reset;
            ST_EMIT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tkeep  = 4'hF;
                m_axis_tdata  = ftw_s;
                m_axis_tlast  = beat_last_s;
            end
            ST_DONE: s_axis_tready = 1'b0;
            default: s_axis_tready = 1'b0;
        endcase
    end

    assign err_keep  = err_keep_r;
    assign state_reg = state_r;

endmodule

// File: tb/tb_fsk_bit_mapper.sv
// Self-checking bench for fsk_bit_mapper: directed vector table, hand-written
// reset sequences and randomized words checked against a bit-level model.
module tb_fsk_bit_mapper;
    import fsk_pkg::*;

    localparam int REPEAT    = 4;
    localparam bit MSB_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] cfg_ftw_mark;
    logic [31:0] cfg_ftw_space;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        err_keep;
    logic [1:0]  state_reg;

    always #5 clk = ~clk;

    fsk_bit_mapper #(.REPEAT(REPEAT), .MSB_FIRST(MSB_FIRST)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .cfg_ftw_mark  (cfg_ftw_mark),
        .cfg_ftw_space (cfg_ftw_space),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_keep      (err_keep),
        .state_reg     (state_reg)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] mark;
        logic [31:0] space;
        int          rdy_pct;
        int          chg_at;
        logic [31:0] chg_val;
        logic        exp_err;
    } vec_t;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    vec_t  vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int model_bytes(input logic [3:0] k);
        case (k)
            4'h1:    return 1;
            4'h3:    return 2;
            4'h7:    return 3;
            4'hF:    return 4;
            default: return 0;
        endcase
    endfunction

    // Reference: every valid bit in transmit order, REPEAT copies of its tuning word.
    task automatic build_expected(input logic [31:0] d, input logic [3:0] k, input logic l,
                                  input logic [31:0] mk, input logic [31:0] sp);
        int    n;
        beat_t b;
        logic  bitv;
        exp_q.delete();
        n = 8 * model_bytes(k);
        for (int j = 0; j < n; j++) begin
            bitv = MSB_FIRST ? d[n - 1 - j] : d[j];
            for (int r = 0; r < REPEAT; r++) begin
                b.d = bitv ? mk : sp;
                b.l = l && (j == n - 1) && (r == REPEAT - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Called and returns on a falling edge with the DUT expected in IDLE.
    task automatic do_word(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [31:0] mk, input logic [31:0] sp, input int rdy_pct,
                           input int chg_at, input logic [31:0] chg_val, input logic exp_err);
        int          g;
        int          idx;
        bit          stalled;
        logic [31:0] prev_d;
        logic        prev_l;
        build_expected(d, k, l, mk, sp);
        cfg_ftw_mark  = mk;
        cfg_ftw_space = sp;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        g = 0;
        while (!s_axis_tready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!s_axis_tready) begin
            n_cmp++;
            n_err++;
            $display("FAIL slave_ready_timeout: got tready=0 for %0d cycles, expected 1", g);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tkeep  = 4'h0;
        s_axis_tlast  = 1'b0;
        chk("err_keep_pulse", {31'h0, err_keep}, {31'h0, exp_err});
        if (exp_q.size() == 0) begin
            chk("no_beat_on_err", {31'h0, m_axis_tvalid}, 32'h0);
            chk("idle_after_err", {31'h0, s_axis_tready}, 32'h1);
            @(negedge clk);
            chk("err_keep_clear", {31'h0, err_keep}, 32'h0);
            return;
        end
        idx     = 0;
        stalled = 1'b0;
        prev_d  = 32'h0;
        prev_l  = 1'b0;
        g       = 0;
        while (idx < exp_q.size() && g < 8000) begin
            chk("m_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
            chk("s_tready_busy", {31'h0, s_axis_tready}, 32'h0);
            if (stalled) begin
                chk("stall_tdata", m_axis_tdata, prev_d);
                chk("stall_tlast", {31'h0, m_axis_tlast}, {31'h0, prev_l});
            end
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            if (m_axis_tready) begin
                chk($sformatf("beat%0d_tdata", idx), m_axis_tdata, exp_q[idx].d);
                chk($sformatf("beat%0d_tlast", idx), {31'h0, m_axis_tlast}, {31'h0, exp_q[idx].l});
                chk("beat_tkeep", {28'h0, m_axis_tkeep}, 32'hF);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_d  = m_axis_tdata;
                prev_l  = m_axis_tlast;
            end
            if (idx == chg_at) cfg_ftw_mark = chg_val;
            @(negedge clk);
            g++;
        end
        if (idx < exp_q.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL emit_timeout: got %0d beats, expected %0d", idx, exp_q.size());
        end
        if (rdy_pct >= 100) chk("emit_cycles", g, exp_q.size());
        m_axis_tready = 1'b0;
        chk("done_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("done_s_tready", {31'h0, s_axis_tready}, 32'h0);
        chk("done_state", {30'h0, state_reg}, {30'h0, ST_DONE});
        @(negedge clk);
        chk("idle_s_tready", {31'h0, s_axis_tready}, 32'h1);
        chk("idle_state", {30'h0, state_reg}, {30'h0, ST_IDLE});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h80000001, 4'hF, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b0};
        vecs[1] = '{32'h000000A5, 4'h1, 1'b0, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b0};
        vecs[2] = '{32'h00000005, 4'h5, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b1};
        vecs[3] = '{32'h0000C3F0, 4'h3, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b0};
        vecs[4] = '{32'h00ABCDEF, 4'h7, 1'b0, FTW_2MHZ_50M, FTW_1MHZ_50M, 50,  -1, 32'h0, 1'b0};
        vecs[5] = '{32'h80000001, 4'hF, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 50,  -1, 32'h0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 4'h0, 1'b0, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b1};
        vecs[7] = '{32'h12345678, 4'hF, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, 20, 32'h12345678, 1'b0};
        vecs[8] = '{32'hF0F0F0F0, 4'hF, 1'b0, 32'h12345678, FTW_1MHZ_50M, 50, -1, 32'h0, 1'b0};

        reset         = 1'b1;
        s_axis_tdata  = 32'h0;
        s_axis_tkeep  = 4'h0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        cfg_ftw_mark  = FTW_2MHZ_50M;
        cfg_ftw_space = FTW_1MHZ_50M;
        m_axis_tready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("rst_m_tdata", m_axis_tdata, 32'h0);
        chk("rst_m_tkeep", {28'h0, m_axis_tkeep}, 32'h0);
        chk("rst_s_tready", {31'h0, s_axis_tready}, 32'h0);
        chk("rst_err_keep", {31'h0, err_keep}, 32'h0);
        chk("rst_state", {30'h0, state_reg}, {30'h0, ST_IDLE});
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", {31'h0, s_axis_tready}, 32'h1);
        chk("post_rst_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);

        for (int i = 0; i < 9; i++) begin
            do_word(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].mark, vecs[i].space,
                    vecs[i].rdy_pct, vecs[i].chg_at, vecs[i].chg_val, vecs[i].exp_err);
        end

        // Reset asserted mid-word, away from any clock edge.
        cfg_ftw_mark  = FTW_2MHZ_50M;
        cfg_ftw_space = FTW_1MHZ_50M;
        s_axis_tdata  = 32'hDEADBEEF;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_word_state", {30'h0, state_reg}, {30'h0, ST_EMIT});
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        chk("async_rst_m_tlast", {31'h0, m_axis_tlast}, 32'h0);
        chk("async_rst_m_tdata", m_axis_tdata, 32'h0);
        chk("async_rst_state", {30'h0, state_reg}, {30'h0, ST_IDLE});
        @(negedge clk);
        reset         = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("rerun_s_tready", {31'h0, s_axis_tready}, 32'h1);
        chk("rerun_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        do_word(32'h80000001, 4'hF, 1'b1, FTW_2MHZ_50M, FTW_1MHZ_50M, 100, -1, 32'h0, 1'b0);

        // Randomized words, occasionally with an arbitrary (possibly illegal) keep.
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  kk;
            logic [31:0] rd;
            logic [31:0] rm;
            logic [31:0] rs;
            int          sel;
            sel = $urandom_range(4);
            case (sel)
                0:       kk = 4'h1;
                1:       kk = 4'h3;
                2:       kk = 4'h7;
                3:       kk = 4'hF;
                default: kk = 4'($urandom_range(15));
            endcase
            rd = $urandom;
            rm = $urandom;
            rs = $urandom;
            do_word(rd, kk, 1'($urandom_range(1)), rm, rs, $urandom_range(100, 30), -1, 32'h0,
                    (model_bytes(kk) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
